// File: rtl/muldiv_sequencer_pkg.sv
// Shared decode constants and FSM state encoding for the iterative M-extension unit.
package muldiv_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [1:0] ALUOP_RTYPE   = 2'b10;

endpackage

// File: rtl/muldiv_sequencer.sv
// Radix-2 sequential multiply/divide unit: one shift-add or restoring-divide step per cycle,
// operating on magnitudes with sign fix-up applied as the result is captured.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Result
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  state_t           state;
  logic [CNT_W-1:0] iter_cnt;
  logic [2:0]       op;
  logic             neg_q;
  logic             neg_r;
  logic [XLEN-1:0]  hi;
  logic [XLEN-1:0]  lo;
  logic [XLEN-1:0]  opb;

  logic             accept;
  logic             a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic             div_zero, div_ovf;
  logic [XLEN-1:0]  fast_res;

  assign accept   = (state == ST_IDLE) && start && (ALUOp == ALUOP_RTYPE) && (Funct7 == FUNCT7_MULDIV);
  assign a_signed = (Funct3 == F3_MULH) || (Funct3 == F3_MULHSU) || (Funct3 == F3_DIV) || (Funct3 == F3_REM);
  assign b_signed = (Funct3 == F3_MULH) || (Funct3 == F3_DIV) || (Funct3 == F3_REM);
  assign a_neg    = a_signed && SrcA[XLEN-1];
  assign b_neg    = b_signed && SrcB[XLEN-1];
  assign a_mag    = cond_neg(SrcA, a_neg);
  assign b_mag    = cond_neg(SrcB, b_neg);
  assign div_zero = Funct3[2] && (SrcB == '0);
  assign div_ovf  = ((Funct3 == F3_DIV) || (Funct3 == F3_REM)) && (SrcA == MOST_NEG) && (SrcB == '1);

  // Degenerate divides bypass the iteration: zero divisor first, then signed overflow.
  always_comb begin
    fast_res = '0;
    if (div_zero)
      fast_res = Funct3[1] ? SrcA : '1;
    else if (div_ovf)
      fast_res = Funct3[1] ? '0 : SrcA;
  end

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic [XLEN-1:0] hi_nx, lo_nx;

  // hi holds the running partial product / remainder; lo holds multiplier / dividend bits.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
    div_shift = {hi, lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb};
    if (op[2]) begin
      if (!div_diff[XLEN]) begin
        hi_nx = div_diff[XLEN-1:0];
        lo_nx = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nx = div_shift[XLEN-1:0];
        lo_nx = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nx = mul_sum[XLEN:1];
      lo_nx = {mul_sum[0], lo[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    prod_fix  = cond_neg_wide({hi_nx, lo_nx}, neg_q);
    final_res = '0;
    case (op)
      F3_MUL:                       final_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              final_res = cond_neg(lo_nx, neg_q);
      default:                      final_res = cond_neg(hi_nx, neg_r);
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      iter_cnt <= '0;
      op       <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      opb      <= '0;
      Result   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op    <= Funct3;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            if (div_zero || div_ovf) begin
              Result <= fast_res;
              state  <= ST_DONE;
            end else begin
              hi       <= '0;
              lo       <= a_mag;
              opb      <= b_mag;
              iter_cnt <= '0;
              state    <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          hi       <= hi_nx;
          lo       <= lo_nx;
          iter_cnt <= iter_cnt + CNT_W'(1);
          if (iter_cnt == LAST_ITER) begin
            Result   <= final_res;
            iter_cnt <= '0;
            state    <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with a queue-based scoreboard and independent done monitor.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      ALUOp = '0;
  logic [6:0]      Funct7 = '0;
  logic [2:0]      Funct3 = '0;
  logic [XLEN-1:0] SrcA = '0;
  logic [XLEN-1:0] SrcB = '0;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] Result;

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUOp(ALUOp), .Funct7(Funct7),
    .Funct3(Funct3), .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done), .Result(Result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [XLEN-1:0] res;
    int              lat;
    int              acc;
    string           name;
  } exp_t;

  exp_t            sb[$];
  int              n_vec = 0;
  int              n_miss = 0;
  logic [XLEN-1:0] last_res = '0;
  int              busy_run = 0;
  int              last_busy_run = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Latency is the number of rising edges after acceptance up to the one that samples done high.
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (reset && done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_done: got done with Result %h, want no done", Result);
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, Result, e.res);
        lat = cyc - e.acc + 1;
        n_vec++;
        if (lat != e.lat) begin
          n_miss++;
          $display("FAIL %s_latency: got %0d, want %0d", e.name, lat, e.lat);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (busy === 1'b1) busy_run++;
    else if (busy_run > 0) begin
      last_busy_run = busy_run;
      busy_run = 0;
    end
  end

  task automatic issue(input string name, input logic [2:0] f3, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] expv, input int lat);
    @(negedge clk);
    start = 1'b1; ALUOp = ALUOP_RTYPE; Funct7 = FUNCT7_MULDIV; Funct3 = f3; SrcA = a; SrcB = b;
    @(posedge clk);
    #1;
    start = 1'b0; SrcA = $urandom; SrcB = $urandom; Funct3 = 3'($urandom);
    sb.push_back('{expv, lat, cyc, name});
    if (lat > 1) begin
      @(negedge clk);
      @(negedge clk);
      check({name, "_prev_held"}, Result, last_res);
    end
    last_res = expv;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy === 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_timeout: got busy after %0d cycles, want idle", name, k);
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_result", Result, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    issue("mul_7_m3", F3_MUL, 32'h7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    wait_idle("mul_7_m3");
    check("mul_busy_cycles", 32'(last_busy_run), 32'd33);

    issue("mulhu_ones", F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    wait_idle("mulhu_ones");
    issue("mulh_ones", F3_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    wait_idle("mulh_ones");
    issue("mulhsu_m1_2", F3_MULHSU, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 33);
    wait_idle("mulhsu_m1_2");
    issue("mul_shift", F3_MUL, 32'h12345678, 32'h10, 32'h23456780, 33);
    wait_idle("mul_shift");
    issue("div_m7_2", F3_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 33);
    wait_idle("div_m7_2");
    issue("rem_m7_2", F3_REM, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 33);
    wait_idle("rem_m7_2");
    issue("divu_100_7", F3_DIVU, 32'd100, 32'd7, 32'd14, 33);
    wait_idle("divu_100_7");
    issue("remu_100_7", F3_REMU, 32'd100, 32'd7, 32'd2, 33);
    wait_idle("remu_100_7");
    issue("divu_by0", F3_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
    wait_idle("divu_by0");
    check("fast_busy_cycles", 32'(last_busy_run), 32'd1);
    issue("remu_by0", F3_REMU, 32'd7, 32'd0, 32'd7, 1);
    wait_idle("remu_by0");
    issue("div_ovf", F3_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    wait_idle("div_ovf");
    issue("rem_ovf", F3_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    wait_idle("rem_ovf");

    // Requests that must not be accepted.
    @(negedge clk);
    start = 1'b1; ALUOp = ALUOP_RTYPE; Funct7 = 7'b0000000; Funct3 = F3_MUL; SrcA = 32'd3; SrcB = 32'd3;
    @(negedge clk);
    start = 1'b0;
    check("reject_funct7_busy", {31'b0, busy}, 32'h0);
    start = 1'b1; ALUOp = 2'b00; Funct7 = FUNCT7_MULDIV;
    @(negedge clk);
    start = 1'b0;
    check("reject_aluop_busy", {31'b0, busy}, 32'h0);

    issue("mul_3_5", F3_MUL, 32'd3, 32'd5, 32'd15, 33);
    repeat (3) @(negedge clk);
    start = 1'b1; ALUOp = ALUOP_RTYPE; Funct7 = FUNCT7_MULDIV; Funct3 = F3_DIVU; SrcA = 32'd99; SrcB = 32'd0;
    @(negedge clk);
    start = 1'b0;
    wait_idle("mul_3_5");
    repeat (3) @(negedge clk);
    check("ignored_start_busy", {31'b0, busy}, 32'h0);
    check("ignored_start_result", Result, 32'd15);

    // Abort an in-flight multiply with reset.
    @(negedge clk);
    start = 1'b1; ALUOp = ALUOP_RTYPE; Funct7 = FUNCT7_MULDIV; Funct3 = F3_MUL; SrcA = 32'd9; SrcB = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_done", {31'b0, done}, 32'h0);
    check("abort_result", Result, 32'h0);
    last_res = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    issue("mul_3_4", F3_MUL, 32'd3, 32'd4, 32'h0000000C, 33);
    wait_idle("mul_3_4");

    repeat (5) @(negedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      n_miss++;
      $display("FAIL %s_missing: got no done, want Result %h", e.name, e.res);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
